// File: rtl/fusion_alu_pkg.sv
// fusion_alu_pkg: shared ALU opcode map, flag bit positions and opcode class helpers.
package fusion_alu_pkg;
   localparam int XLEN = 32;
   localparam logic [4:0] OP_NOP = 5'd0, OP_AND = 5'd1, OP_OR = 5'd2, OP_XOR = 5'd3, OP_NOT = 5'd4;
   localparam logic [4:0] OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_ROL = 5'd8, OP_SLT = 5'd9;
   localparam logic [4:0] OP_ADD = 5'd16, OP_SUB = 5'd17, OP_INC = 5'd18, OP_DEC = 5'd19;
   localparam int FLG_CARRY = 3, FLG_OVF = 2, FLG_PAR = 1, FLG_NEG = 0;
   function automatic logic is_reserved(input logic [4:0] op);
      return (op >= 5'd10 && op <= 5'd15) || op >= 5'd20;
   endfunction
   function automatic logic is_arith(input logic [4:0] op);
      return op >= OP_ADD && op <= OP_DEC;
   endfunction
endpackage

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: valid/ready pipeline register; payload only loads with a valid entry.
module alu_issue_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);
   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   always_comb begin
      valid_d = en_i ? valid_i : valid_q;
      data_d  = (en_i && valid_i) ? data_i : data_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-stage ALU issue/capture pipeline with writeback handshake and sticky flags.
// Define ALU_ISSUE_PERF_EN to add the perf_retired/perf_stall counters.
module alu_issue_ctrl #(
   parameter int XLEN = 32,
   parameter int OPW  = 5,
   parameter int RDW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_opcode,
   input  logic [RDW-1:0]  in_rd,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic [XLEN-1:0] alu_op_a,
   output logic [XLEN-1:0] alu_op_b,
   output logic [OPW-1:0]  alu_op_code,
   input  logic [XLEN-1:0] alu_out,
   input  logic [3:0]      alu_flags,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RDW-1:0]  wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_err,
   output logic [3:0]      status_flags
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]     perf_retired,
   output logic [31:0]     perf_stall
`endif
);
   import fusion_alu_pkg::*;
   localparam int S1W = OPW + RDW + 2 * XLEN;
   localparam int S2W = RDW + XLEN + 1;
   logic           s1_valid, adv1, adv2, cap_valid, err;
   logic [RDW-1:0] s1_rd;
   logic [S1W-1:0] s1_data;
   logic [S2W-1:0] s2_data;
   logic [3:0]     status_q, status_d;
   assign adv2      = !wb_valid || wb_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign {alu_op_code, s1_rd, alu_op_a, alu_op_b} = s1_data;
   assign err       = is_reserved(alu_op_code);
   // NOPs retire silently: they advance out of stage 1 but leave a bubble in stage 2
   assign cap_valid = s1_valid && alu_op_code != '0;
   alu_issue_stage #(.W(S1W)) u_issue (
      .clk(clk), .rst(rst), .en_i(adv1), .valid_i(in_valid),
      .data_i({in_opcode, in_rd, in_a, in_b}), .valid_o(s1_valid), .data_o(s1_data)
   );
   alu_issue_stage #(.W(S2W)) u_capture (
      .clk(clk), .rst(rst), .en_i(adv2), .valid_i(cap_valid),
      .data_i({s1_rd, err ? '0 : alu_out, err}), .valid_o(wb_valid), .data_o(s2_data)
   );
   assign {wb_rd, wb_data, wb_err} = s2_data;
   always_comb begin
      status_d = (s1_valid && adv2 && is_arith(alu_op_code)) ? alu_flags : status_q;
   end
   always_ff @(posedge clk) begin
      if (rst) status_q <= '0;
      else status_q <= status_d;
   end
   assign status_flags = status_q;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] retired_q, retired_d, stall_q, stall_d;
   always_comb begin
      retired_d = retired_q + {31'd0, wb_valid && wb_ready};
      stall_d   = stall_q + {31'd0, in_valid && !in_ready};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         retired_q <= retired_d;
         stall_q   <= stall_d;
      end
   end
   assign perf_retired = retired_q;
   assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random stimulus against an in-order writeback queue model.
module tb_alu_issue_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, wb_valid, wb_ready = 1'b1, wb_err;
   logic [4:0]  in_opcode = '0, in_rd = '0, alu_op_code, wb_rd;
   logic [31:0] in_a = '0, in_b = '0, alu_op_a, alu_op_b, alu_out, wb_data;
   logic [3:0]  alu_flags, status_flags, saved;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_retired, perf_stall;
   int          m_ret = 0, m_stall = 0;
`endif
   typedef struct {logic [4:0] rd; logic [31:0] data; logic err; logic [3:0] st;} exp_t;
   exp_t        q[$];
   logic [3:0]  m_status = '0;
   int          vectors = 0, errors = 0, n_ret = 0, base, accepted;
   always #5 clk = ~clk;
   alu_issue_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_rd(in_rd), .in_a(in_a), .in_b(in_b), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
      .alu_op_code(alu_op_code), .alu_out(alu_out), .alu_flags(alu_flags), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
      .status_flags(status_flags)
`ifdef ALU_ISSUE_PERF_EN
      , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
   );
   function automatic logic [35:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r, bb;
      logic        c, v;
      c = 1'b0; v = 1'b0; w = '0;
      bb = (op == 5'd18 || op == 5'd19) ? 32'd1 : b;
      case (op)
         5'd1: r = a & b;
         5'd2: r = a | b;
         5'd3: r = a ^ b;
         5'd4: r = ~a;
         5'd5: r = a << b[4:0];
         5'd6: r = a >> b[4:0];
         5'd7: r = $signed(a) >>> b[4:0];
         5'd9: r = {31'd0, $signed(a) < $signed(b)};
         5'd16, 5'd18: begin w = {1'b0, a} + {1'b0, bb}; r = w[31:0]; c = w[32]; v = (a[31] == bb[31]) && (r[31] != a[31]); end
         5'd17, 5'd19: begin w = {1'b0, a} - {1'b0, bb}; r = w[31:0]; c = w[32]; v = (a[31] != bb[31]) && (r[31] != a[31]); end
         default: r = a ^ b ^ {27'd0, op};
      endcase
      return {c, v, ^r, r[31], r};
   endfunction
   always_comb {alu_flags, alu_out} = alu_f(alu_op_code, alu_op_a, alu_op_b);
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      logic [35:0] r;
      logic        res;
      if (rst) begin
         q.delete();
         m_status = '0;
`ifdef ALU_ISSUE_PERF_EN
         m_ret = 0; m_stall = 0;
`endif
      end else begin
         if (wb_valid) begin
            chk("wb_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               chk("wb_rd", 32'(wb_rd), 32'(q[0].rd));
               chk("wb_data", wb_data, q[0].data);
               chk("wb_err", 32'(wb_err), 32'(q[0].err));
               chk("status", 32'(status_flags), 32'(q[0].st));
               if (wb_ready) begin
                  void'(q.pop_front());
                  n_ret++;
               end
            end
         end
`ifdef ALU_ISSUE_PERF_EN
         if (wb_valid && wb_ready) m_ret++;
         if (in_valid && !in_ready) m_stall++;
`endif
         if (in_valid && in_ready && in_opcode != 5'd0) begin
            r = alu_f(in_opcode, in_a, in_b);
            res = (in_opcode >= 5'd10 && in_opcode <= 5'd15) || in_opcode >= 5'd20;
            if (in_opcode >= 5'd16 && in_opcode <= 5'd19) m_status = r[35:32];
            q.push_back('{in_rd, res ? 32'd0 : r[31:0], res, m_status});
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
      logic acc;
      in_valid = 1'b1; in_opcode = op; in_rd = rd; in_a = a; in_b = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         if (acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      vectors++; errors++;
      $display("FAIL send_timeout: op %0d not accepted within 50 cycles", op);
   endtask
   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic bp_run(input int cycles, input int stop_at);
      logic [4:0]  ops[3] = '{5'd16, 5'd2, 5'd3};
      logic [31:0] as[3] = '{32'd10, 32'h0F, 32'd3};
      logic [31:0] bs[3] = '{32'd20, 32'hF0, 32'd5};
      for (int c = 0; c < cycles && accepted < stop_at; c++) begin
         in_valid = 1'b1;
         in_opcode = ops[accepted]; in_rd = 5'(accepted + 1); in_a = as[accepted]; in_b = bs[accepted];
         @(negedge clk);
         if (in_ready) accepted++;
         tick();
      end
      in_valid = 1'b0;
   endtask
   initial begin
      tick(); tick();
      rst = 1'b0;
      chk("rst_wb_valid", 32'(wb_valid), 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", 32'(wb_rd), 0);
      chk("rst_status", 32'(status_flags), 0);
      chk("rst_alu_a", alu_op_a, 0);
      chk("rst_alu_code", 32'(alu_op_code), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      send(5'd16, 5'd7, 32'd5, 32'd3);
      chk("add_latency_n", 32'(wb_valid), 0);
      tick();
      chk("add_wb_valid", 32'(wb_valid), 1);
      chk("add_data", wb_data, 32'd8);
      chk("add_rd", 32'(wb_rd), 7);
      chk("add_status", 32'(status_flags), 32'h2);
      idle(3);
      send(5'd17, 5'd1, 32'd2, 32'd3);
      send(5'd3, 5'd2, 32'hF0, 32'hFF);
      chk("sub_data", wb_data, 32'hFFFF_FFFF);
      chk("sub_status", 32'(status_flags), 32'h9);
      tick();
      chk("xor_data", wb_data, 32'h0F);
      chk("xor_status", 32'(status_flags), 32'h9);
      idle(3);
      wb_ready = 1'b0; accepted = 0; base = n_ret;
      bp_run(4, 3);
      chk("bp_accepts", 32'(accepted), 2);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold", wb_data, 32'd30);
      wb_ready = 1'b1;
      bp_run(10, 3);
      idle(4);
      chk("bp_retired", 32'(n_ret - base), 3);
      saved = status_flags;
      send(5'd0, 5'd1, 32'd9, 32'd9);
      send(5'd12, 5'd4, 32'd3, 32'd4);
      chk("nop_bubble", 32'(wb_valid), 0);
      tick();
      chk("rsv_valid", 32'(wb_valid), 1);
      chk("rsv_data", wb_data, 0);
      chk("rsv_err", 32'(wb_err), 1);
      chk("rsv_rd", 32'(wb_rd), 4);
      chk("rsv_status", 32'(status_flags), 32'(saved));
      idle(3);
      send(5'd16, 5'd5, 32'hFFFF_FFFF, 32'd1);
      tick();
      chk("carry_data", wb_data, 0);
      chk("carry_status", 32'(status_flags), 32'h8);
      send(5'd1, 5'd6, 32'hFF, 32'h0F);
      tick();
      chk("and_data", wb_data, 32'h0F);
      chk("and_status", 32'(status_flags), 32'h8);
      idle(3);
      wb_ready = 1'b0;
      send(5'd16, 5'd1, 32'd1, 32'd1);
      send(5'd16, 5'd2, 32'd2, 32'd2);
      chk("pre_rst_in_ready", 32'(in_ready), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_wb_valid", 32'(wb_valid), 0);
      chk("mid_rst_status", 32'(status_flags), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
`ifdef ALU_ISSUE_PERF_EN
      chk("mid_rst_retired", perf_retired, 0);
      chk("mid_rst_stall", perf_stall, 0);
`endif
      for (int i = 0; i < 800; i++) begin
         in_valid = $urandom_range(0, 3) != 0;
         in_opcode = 5'($urandom_range(0, 31));
         in_rd = 5'($urandom);
         in_a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
         in_b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         wb_ready = $urandom_range(0, 9) < 7;
         tick();
      end
      wb_ready = 1'b1;
      idle(6);
      chk("drain_empty", 32'(q.size()), 0);
`ifdef ALU_ISSUE_PERF_EN
      chk("perf_retired", perf_retired, 32'(m_ret));
      chk("perf_stall", perf_stall, 32'(m_stall));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
